// File: rtl/rv32i_mem_pkg.sv
// rtl/rv32i_mem_pkg.sv - shared RV32I data-memory definitions
// Contents: funct3 encodings, responder FSM state type, byte-enable and
// funct3-legality helpers shared by the responder and the lane aligner.
package rv32i_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // 011, 110 and 111 have no RV32I load/store meaning.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  // Byte enables for a store; bit 2 of funct3 (unsigned) does not affect size.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    if (!f3_illegal(f3)) begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << addr_lo;
        2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
        2'b10:   be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// rtl/ls_lane_align.sv - RV32I store lane placement and load extraction
// Ports:
//   funct3     in  3   size/sign code
//   addr_lo    in  2   byte offset within the word
//   st_data    in  32  LSB-justified store data
//   ld_word    in  32  full word read from memory
//   st_be      out 4   per-byte write enables
//   st_lanes   out 32  store data replicated into every lane
//   ld_data    out 32  selected lane, sign/zero extended
//   align_err  out 1   misaligned access or illegal funct3
module ls_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data,
  output logic        align_err
);

  logic [15:0] shifted;

  always_comb begin
    st_be     = byte_en(funct3, addr_lo);
    shifted   = 16'(ld_word >> {addr_lo, 3'b000});
    st_lanes  = st_data;
    ld_data   = 32'd0;
    align_err = f3_illegal(funct3);
    case (funct3)
      F3_LB: begin
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_LBU: begin
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {24'd0, shifted[7:0]};
      end
      F3_LH: begin
        st_lanes  = {2{st_data[15:0]}};
        ld_data   = {{16{shifted[15]}}, shifted[15:0]};
        align_err = addr_lo[0];
      end
      F3_LHU: begin
        st_lanes  = {2{st_data[15:0]}};
        ld_data   = {16'd0, shifted[15:0]};
        align_err = addr_lo[0];
      end
      F3_LW: begin
        ld_data   = ld_word;
        align_err = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - RV32I data-memory responder with wait states
// Ports:
//   i_clk, i_rst                 clock; asynchronous active-high reset
//   i_req_valid / o_req_ready    request handshake
//   i_req_we, i_req_addr, i_req_wdata, i_req_funct3  request fields
//   o_rsp_valid / i_rsp_ready    response handshake
//   o_rsp_rdata, o_rsp_err       response fields
module data_mem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_funct3,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam bit          HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0]  CNT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        accept;
  logic        range_err, align_err, req_err;
  logic [AW-1:0] word_idx;
  logic [3:0]  st_be;
  logic [31:0] st_lanes, ld_word, ld_data, rsp_now;
  logic [31:0] hold_rdata;
  logic        hold_err;
  logic        entering_resp, leaving_resp;

  assign word_idx    = i_req_addr[AW+1:2];
  assign range_err   = |i_req_addr[31:AW+2];
  assign ld_word     = mem[word_idx];
  assign req_err     = range_err | align_err;
  assign o_req_ready = (state_q == ST_IDLE) && !i_rst;
  assign accept      = i_req_valid && o_req_ready;
  // Stores and errored accesses report zero data.
  assign rsp_now     = (i_req_we || req_err) ? 32'd0 : ld_data;

  ls_lane_align u_align (
    .funct3    (i_req_funct3),
    .addr_lo   (i_req_addr[1:0]),
    .st_data   (i_req_wdata),
    .ld_word   (ld_word),
    .st_be     (st_be),
    .st_lanes  (st_lanes),
    .ld_data   (ld_data),
    .align_err (align_err)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = HAS_WAIT ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (i_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= CNT_LOAD;
    end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Not reset: a store accepted before a reset stays written.
  always_ff @(posedge i_clk) begin
    if (accept && i_req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_lanes[8*b +: 8];
      end
    end
  end

  assign entering_resp = (state_q != ST_RESP) && (state_d == ST_RESP);
  assign leaving_resp  = (state_q == ST_RESP) && (state_d == ST_IDLE);

  // Load result is captured at acceptance so later stores cannot disturb it;
  // with no wait states the live value goes straight to the outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_rdata  <= 32'd0;
      hold_err    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        hold_rdata <= rsp_now;
        hold_err   <= req_err;
      end
      if (entering_resp) begin
        o_rsp_valid <= 1'b1;
        o_rsp_rdata <= (state_q == ST_IDLE) ? rsp_now : hold_rdata;
        o_rsp_err   <= (state_q == ST_IDLE) ? req_err : hold_err;
      end else if (leaving_resp) begin
        o_rsp_valid <= 1'b0;
        o_rsp_rdata <= 32'd0;
        o_rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst(rst[0]),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we[0]), .i_req_addr(req_addr[0]),
    .i_req_wdata(req_wdata[0]), .i_req_funct3(req_funct3[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_rst(rst[1]),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we[1]), .i_req_addr(req_addr[1]),
    .i_req_wdata(req_wdata[1]), .i_req_funct3(req_funct3[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int s, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         output logic [31:0] rdata, output logic err, output int lat);
    int n;
    rdata = 32'd0;
    err   = 1'b0;
    lat   = 0;
    @(negedge clk);
    req_valid[s]  = 1'b1;
    req_we[s]     = we;
    req_addr[s]   = addr;
    req_wdata[s]  = wdata;
    req_funct3[s] = f3;
    n = 0;
    while (!req_ready[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[s]) begin
      check("req_ready timeout", 32'(req_ready[s]), 32'd1);
      req_valid[s] = 1'b0;
    end else begin
      @(posedge clk);
      #1 req_valid[s] = 1'b0;
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid[s] && lat < 40);
      if (!rsp_valid[s]) begin
        check("rsp_valid timeout", 32'(rsp_valid[s]), 32'd1);
      end else begin
        rdata = rsp_rdata[s];
        err   = rsp_err[s];
        rsp_ready[s] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[s] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [31:0] rd;
  logic        er;
  int          lat;
  bit          seen;

  initial begin
    //            we    addr        wdata         f3      rdata         err
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h13,   32'h00000080, 3'b000, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 32'h13,   32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 32'h13,   32'h0,        3'b100, 32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 32'h10,   32'h0,        3'b010, 32'h80ADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 32'h12,   32'h0,        3'b001, 32'hFFFF80AD, 1'b0};
    vecs[7]  = '{1'b0, 32'h12,   32'h0,        3'b101, 32'h000080AD, 1'b0};
    vecs[8]  = '{1'b0, 32'h11,   32'h0,        3'b001, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b1, 32'h0C,   32'hA5A5A5A5, 3'b010, 32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 32'h0E,   32'h12345678, 3'b010, 32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 32'h0C,   32'h0,        3'b010, 32'hA5A5A5A5, 1'b0};
    vecs[12] = '{1'b1, 32'h10,   32'h1234CAFE, 3'b001, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 32'h10,   32'h0,        3'b010, 32'h80ADCAFE, 1'b0};
    vecs[14] = '{1'b0, 32'h11,   32'h0,        3'b000, 32'hFFFFFFCA, 1'b0};
    vecs[15] = '{1'b0, 32'h12,   32'h0,        3'b100, 32'h000000AD, 1'b0};
    vecs[16] = '{1'b0, 32'h10,   32'h0,        3'b011, 32'h00000000, 1'b1};
    vecs[17] = '{1'b1, 32'h10,   32'h0,        3'b110, 32'h00000000, 1'b1};
    vecs[18] = '{1'b0, 32'h10,   32'h0,        3'b010, 32'h80ADCAFE, 1'b0};
    vecs[19] = '{1'b1, 32'h00,   32'h0BADF00D, 3'b010, 32'h00000000, 1'b0};
    vecs[20] = '{1'b1, 32'h1000, 32'hFFFFFFFF, 3'b010, 32'h00000000, 1'b1};
    vecs[21] = '{1'b0, 32'h1000, 32'h0,        3'b010, 32'h00000000, 1'b1};
    vecs[22] = '{1'b0, 32'h00,   32'h0,        3'b010, 32'h0BADF00D, 1'b0};
    vecs[23] = '{1'b1, 32'h02,   32'h0000BEEF, 3'b001, 32'h00000000, 1'b0};
    vecs[24] = '{1'b0, 32'h00,   32'h0,        3'b010, 32'hBEEFF00D, 1'b0};
    vecs[25] = '{1'b0, 32'h02,   32'h0,        3'b001, 32'hFFFFBEEF, 1'b0};
    vecs[26] = '{1'b0, 32'h00,   32'h0,        3'b101, 32'h0000F00D, 1'b0};
    vecs[27] = '{1'b0, 32'h02,   32'h0,        3'b010, 32'h00000000, 1'b1};
    vecs[28] = '{1'b1, 32'h01,   32'h0000005A, 3'b100, 32'h00000000, 1'b0};
    vecs[29] = '{1'b0, 32'h00,   32'h0,        3'b010, 32'hBEEF5A0D, 1'b0};

    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1;
      req_valid[s] = 1'b0;
      req_we[s] = 1'b0;
      req_addr[s] = 32'd0;
      req_wdata[s] = 32'd0;
      req_funct3[s] = 3'd0;
      rsp_ready[s] = 1'b0;
    end

    // Reset held for three cycles.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        check($sformatf("rst%0d c%0d req_ready", s, c), 32'(req_ready[s]), 32'd0);
        check($sformatf("rst%0d c%0d rsp_valid", s, c), 32'(rsp_valid[s]), 32'd0);
      end
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("post-rst%0d req_ready", s), 32'(req_ready[s]), 32'd1);
      check($sformatf("post-rst%0d rsp_valid", s), 32'(rsp_valid[s]), 32'd0);
      check($sformatf("post-rst%0d rsp_rdata", s), rsp_rdata[s], 32'd0);
      check($sformatf("post-rst%0d rsp_err", s), 32'(rsp_err[s]), 32'd0);
    end

    // Vector table on the zero-wait-state instance.
    for (int i = 0; i < NVEC; i++) begin
      run_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er, lat);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d cleared valid", i), 32'(rsp_valid[0]), 32'd0);
      check($sformatf("vec%0d cleared rdata", i), rsp_rdata[0], 32'd0);
    end

    // Three wait states: latency and response hold under back-pressure.
    run_txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, rd, er, lat);
    check("ws3 store latency", 32'(lat), 32'd4);
    check("ws3 store err", 32'(er), 32'd0);

    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h20; req_funct3[1] = 3'b010;
    @(posedge clk);
    // Conflicting store held on the request port while busy must be ignored.
    #1 req_we[1] = 1'b1; req_wdata[1] = 32'h00000000;
    lat = 0;
    seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready[1]) seen = 1'b1;
    end while (!rsp_valid[1] && lat < 40);
    check("ws3 load latency", 32'(lat), 32'd4);
    check("ws3 ready low while busy", 32'(seen), 32'd0);
    check("ws3 load rdata", rsp_rdata[1], 32'hCAFEF00D);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("ws3 hold%0d valid", c), 32'(rsp_valid[1]), 32'd1);
      check($sformatf("ws3 hold%0d rdata", c), rsp_rdata[1], 32'hCAFEF00D);
      check($sformatf("ws3 hold%0d err", c), 32'(rsp_err[1]), 32'd0);
      check($sformatf("ws3 hold%0d req_ready", c), 32'(req_ready[1]), 32'd0);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[1] = 1'b0;
    @(negedge clk);
    check("ws3 after hs valid", 32'(rsp_valid[1]), 32'd0);
    check("ws3 after hs rdata", rsp_rdata[1], 32'd0);
    check("ws3 after hs req_ready", 32'(req_ready[1]), 32'd1);

    run_txn(1, 1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
    check("ws3 ignored store rdata", rd, 32'hCAFEF00D);

    run_txn(1, 1'b0, 32'h1000, 32'h0, 3'b010, rd, er, lat);
    check("ws3 range err", 32'(er), 32'd1);
    check("ws3 range rdata", rd, 32'd0);
    check("ws3 range latency", 32'(lat), 32'd4);

    // Reset pulsed during WAIT: no response, accepted store remains.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h24;
    req_wdata[1] = 32'h77777777; req_funct3[1] = 3'b010;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    check("rstwait busy req_ready", 32'(req_ready[1]), 32'd0);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    check("rstwait idle req_ready", 32'(req_ready[1]), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid[1]) seen = 1'b1;
    end
    check("rstwait no response", 32'(seen), 32'd0);
    run_txn(1, 1'b0, 32'h24, 32'h0, 3'b010, rd, er, lat);
    check("rstwait store kept", rd, 32'h77777777);
    check("rstwait load err", 32'(er), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
